// File: rtl/microsequencer.sv
// Microprogram sequencer: selects the next microstore address from the control word,
// with an opcode encoder, a moc wait timeout and sticky error flags.
module microsequencer #(
    parameter logic [6:0]  RESET_STATE = 7'd0,
    parameter int unsigned MOC_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] n_sel,
    input  logic       inv,
    input  logic [6:0] cr_addr,
    input  logic       cond,
    input  logic       moc,
    input  logic [5:0] opcode,
    output logic [6:0] current_state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int unsigned STATE_W = 7;
    localparam int unsigned WAIT_W  = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MOC_TIMEOUT - 1);

    logic [STATE_W-1:0] next_state;
    logic [STATE_W-1:0] state_inc;
    logic [STATE_W-1:0] enc_state;
    logic               enc_hit;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_next;
    logic               illegal_set;
    logic               timeout_set;
    logic               waiting;

    assign state_inc = current_state + STATE_W'(1);
    assign waiting   = (n_sel == 3'd5) || (n_sel == 3'd6);

    // Opcode to dispatch-state encoder
    always_comb begin
        enc_hit   = 1'b1;
        enc_state = RESET_STATE;
        case (opcode)
            6'h00:   enc_state = 7'd2;
            6'h08:   enc_state = 7'd3;
            6'h09:   enc_state = 7'd4;
            6'h23:   enc_state = 7'd6;
            6'h2B:   enc_state = 7'd7;
            6'h04:   enc_state = 7'd8;
            6'h05:   enc_state = 7'd9;
            6'h02:   enc_state = 7'd10;
            6'h03:   enc_state = 7'd11;
            default: enc_hit   = 1'b0;
        endcase
    end

    // Next-state select, wait counting and error detection
    always_comb begin
        next_state  = current_state;
        illegal_set = 1'b0;
        timeout_set = 1'b0;
        wait_next   = '0;
        case (n_sel)
            3'd0: begin
                next_state  = enc_state;
                illegal_set = ~enc_hit;
            end
            3'd1: next_state = RESET_STATE;
            3'd2: next_state = cr_addr;
            3'd3: next_state = state_inc;
            3'd4: next_state = (cond ^ inv) ? cr_addr : state_inc;
            3'd5: next_state = moc ? state_inc : current_state;
            3'd6: begin
                if (moc) begin
                    next_state  = enc_state;
                    illegal_set = ~enc_hit;
                end
            end
            default: begin
                next_state  = RESET_STATE;
                illegal_set = 1'b1;
            end
        endcase
        // A moc arriving on the limit edge wins over the timeout
        if (waiting && !moc) begin
            if (wait_cnt == WAIT_LIMIT) begin
                next_state  = RESET_STATE;
                timeout_set = 1'b1;
            end else begin
                wait_next = wait_cnt + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_state <= RESET_STATE;
            illegal_op    <= 1'b0;
            mem_timeout   <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            current_state <= next_state;
            illegal_op    <= illegal_op | illegal_set;
            mem_timeout   <= mem_timeout | timeout_set;
            wait_cnt      <= wait_next;
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Randomized scoreboard bench for microsequencer against a behavioural model.
module tb_microsequencer;

    localparam int TIMEOUT = 16;
    localparam int RS      = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] n_sel = '0;
    logic       inv = 1'b0;
    logic [6:0] cr_addr = '0;
    logic       cond = 1'b0;
    logic       moc = 1'b0;
    logic [5:0] opcode = '0;
    logic [6:0] current_state;
    logic       illegal_op;
    logic       mem_timeout;

    microsequencer #(.RESET_STATE(7'd0), .MOC_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .n_sel(n_sel), .inv(inv), .cr_addr(cr_addr),
        .cond(cond), .moc(moc), .opcode(opcode), .current_state(current_state),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int ill;
        int to;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   enc_map[int];

    // Reference model state
    int m_state = RS;
    int m_cnt   = 0;
    int m_ill   = 0;
    int m_to    = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one registered result per edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("current_state", int'(current_state), e.st);
            check("illegal_op", int'(illegal_op), e.ill);
            check("mem_timeout", int'(mem_timeout), e.to);
        end
    end

    // Drive one control word at a negedge, predict the following edge, advance.
    task automatic step(input int ns, input int iv, input int ca, input int c, input int m, input int op);
        int  nxt;
        int  enc;
        bit  hit;
        exp_t e;
        n_sel   = 3'(ns);
        inv     = 1'(iv);
        cr_addr = 7'(ca);
        cond    = 1'(c);
        moc     = 1'(m);
        opcode  = 6'(op);
        hit = enc_map.exists(op);
        enc = hit ? enc_map[op] : RS;
        nxt = m_state;
        case (ns)
            0: begin nxt = enc; if (!hit) m_ill = 1; end
            1: nxt = RS;
            2: nxt = ca;
            3: nxt = (m_state + 1) % 128;
            4: nxt = ((c ^ iv) != 0) ? ca : (m_state + 1) % 128;
            5: nxt = (m != 0) ? (m_state + 1) % 128 : m_state;
            6: if (m != 0) begin nxt = enc; if (!hit) m_ill = 1; end
            default: begin nxt = RS; m_ill = 1; end
        endcase
        if ((ns == 5 || ns == 6) && m == 0) begin
            if (m_cnt == TIMEOUT - 1) begin
                nxt   = RS;
                m_to  = 1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
        end
        m_state = nxt;
        e.st = m_state; e.ill = m_ill; e.to = m_to;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Asynchronous reset in mid-cycle, held for two edges; returns at a negedge.
    task automatic reset_pulse();
        exp_t e;
        #2 reset = 1'b1;
        #1;
        q.delete();
        check("async_reset_state", int'(current_state), RS);
        check("async_reset_flags", int'({illegal_op, mem_timeout}), 0);
        m_state = RS; m_cnt = 0; m_ill = 0; m_to = 0;
        @(negedge clk);
        repeat (2) begin
            e.st = RS; e.ill = 0; e.to = 0;
            q.push_back(e);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    initial begin
        enc_map[6'h00] = 2;  enc_map[6'h08] = 3;  enc_map[6'h09] = 4;
        enc_map[6'h23] = 6;  enc_map[6'h2B] = 7;  enc_map[6'h04] = 8;
        enc_map[6'h05] = 9;  enc_map[6'h02] = 10; enc_map[6'h03] = 11;

        @(negedge clk);
        reset_pulse();

        // Counting from reset
        repeat (3) step(3, 0, 0, 0, 0, 0);
        // Encoder hit and miss, sticky illegal flag
        step(2, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 6'h23);
        step(0, 0, 0, 0, 0, 6'h3F);
        step(3, 0, 0, 0, 0, 0);
        // Conditional branch polarity
        step(4, 0, 10, 1, 0, 0);
        step(4, 1, 10, 1, 0, 0);
        step(4, 1, 10, 0, 0, 0);
        // Wait-increment resolving before the limit
        step(2, 0, 5, 0, 0, 0);
        repeat (4) step(5, 0, 0, 0, 0, 0);
        step(5, 0, 0, 0, 1, 0);
        // Wait-encode running into the timeout
        reset_pulse();
        step(2, 0, 20, 0, 0, 0);
        repeat (TIMEOUT) step(6, 0, 0, 0, 0, 6'h09);
        // moc on the limit edge wins
        reset_pulse();
        repeat (TIMEOUT - 1) step(6, 0, 0, 0, 0, 6'h2B);
        step(6, 0, 0, 0, 1, 6'h2B);
        // Incrementer wrap and reserved select
        step(2, 0, 127, 0, 0, 0);
        step(3, 0, 0, 0, 0, 0);
        step(7, 0, 0, 0, 0, 0);
        // Reset in the middle of a wait discards the partial count
        reset_pulse();
        repeat (10) step(5, 0, 0, 0, 0, 0);
        reset_pulse();
        repeat (TIMEOUT - 1) step(5, 0, 0, 0, 0, 0);
        step(5, 0, 0, 0, 1, 0);

        // Randomized traffic with occasional long waits and resets
        for (int i = 0; i < 1500; i++) begin
            int ns;
            int ca;
            int op;
            if ($urandom_range(0, 299) == 0) reset_pulse();
            ns = int'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) ns = 7;
            ca = ($urandom_range(0, 7) == 0) ? 127 : int'($urandom_range(0, 127));
            op = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 63)) : 6'h08;
            if ((ns == 5 || ns == 6) && $urandom_range(0, 3) == 0) begin
                int len;
                len = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
                for (int k = 0; k < len; k++) step(ns, 0, 0, 0, 0, op);
                step(ns, 0, 0, 0, 1, op);
            end else begin
                step(ns, int'($urandom_range(0, 1)), ca, int'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? 1 : 0, op);
            end
        end

        @(negedge clk);
        check("queue_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 Parameter RESET_STATE, default 7'd0: state loaded on reset and on any abort.
REQ-002 Parameter MOC_TIMEOUT, default 16: maximum cycles spent waiting for moc before abort, range 2..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 n_sel  input  3  next-state select field from the current control word.
REQ-006 inv  input  1  condition-invert bit from the control word.
REQ-007 cr_addr  input  7  branch/target state from the control word.
REQ-008 cond  input  1  condition-tester result.
REQ-009 moc  input  1  memory-operation-complete handshake from memory.
REQ-010 opcode  input  6  IR[31:26] for the encoder.
REQ-011 current_state  output  7  registered state driven to the microstore.
REQ-012 illegal_op  output  1  sticky: encoder hit an unmapped opcode.
REQ-013 mem_timeout  output  1  sticky: a moc wait exceeded MOC_TIMEOUT.

Function
REQ-014 The block SHALL compute next_state combinationally from n_sel and register it into current_state on each rising clk edge, with one cycle of latency from inputs to current_state.
REQ-015 n_sel decode: 0 encoder; 1 RESET_STATE; 2 cr_addr; 3 current_state+1; 4 conditional branch; 5 wait-increment; 6 wait-encode; 7 reserved.
REQ-016 The incrementer SHALL be 7 bits wide and wrap, so 7'd127+1 = 7'd0.
REQ-017 Conditional branch SHALL take cr_addr when (cond XOR inv)=1, else current_state+1.
REQ-018 Wait-increment SHALL go to current_state+1 when moc=1, else hold current_state.
REQ-019 Wait-encode SHALL go to the encoder result when moc=1, else hold current_state.
REQ-020 Encoder map: 6'h00->7'd2; 6'h08->7'd3; 6'h09->7'd4; 6'h23->7'd6; 6'h2B->7'd7; 6'h04->7'd8; 6'h05->7'd9; 6'h02->7'd10; 6'h03->7'd11.
REQ-021 Any other opcode SHALL give RESET_STATE and set illegal_op on that clock edge.
REQ-022 A wait counter (8 bits) SHALL clear on every edge where n_sel is neither 5 nor 6, or where moc=1.
REQ-023 The wait counter SHALL increment on every edge where n_sel is 5 or 6 and moc=0.
REQ-024 When n_sel is 5 or 6, moc=0 and the counter equals MOC_TIMEOUT-1, next_state SHALL be RESET_STATE, mem_timeout SHALL set and the counter SHALL clear.
REQ-025 If moc=1 arrives on that same edge, moc SHALL win: normal transition, no timeout.
REQ-026 n_sel=7 SHALL go to RESET_STATE and set illegal_op.
REQ-027 illegal_op and mem_timeout SHALL stay set until reset; further events leave them set.
REQ-028 Inputs SHALL be sampled only at the rising edge; glitches between edges have no effect.

Reset
REQ-029 While reset=1, current_state SHALL be RESET_STATE, both flags 0 and the wait counter 0, taking effect immediately without a clock edge.
REQ-030 Reset asserted mid-wait SHALL discard the partial count.
REQ-031 After reset deasserts, the first rising edge SHALL perform a normal next-state evaluation.

Verification
REQ-032 Reset pulse, then n_sel=3 for 3 edges -> current_state 0,1,2,3; hold reset with clk running -> stays 0.
REQ-033 current_state=1, n_sel=0, opcode=6'h23 -> next edge current_state=6, illegal_op=0; opcode=6'h3F -> current_state=0, illegal_op=1 and stays 1.
REQ-034 n_sel=4, cr_addr=7'd10: cond=1/inv=0 -> 10; cond=1/inv=1 -> current+1; cond=0/inv=1 -> 10.
REQ-035 current_state=5, n_sel=5, moc=0 for 4 edges then moc=1 -> holds 5 for 4 edges, then 6, mem_timeout=0.
REQ-036 MOC_TIMEOUT=16, n_sel=6, moc held 0 -> 15 edges holding, 16th edge -> current_state=0, mem_timeout=1; repeat with moc=1 on the 16th edge -> encoder state, no timeout.
REQ-037 Force current_state=127 via n_sel=2/cr_addr=127, then n_sel=3 -> 0; reset asserted asynchronously mid-wait -> current_state=0 before the next edge.
